// File: rtl/keypad_pkg.sv
// keypad_pkg: key-code layout and entry-FSM state encoding shared by the scanner and keypad_entry.
package keypad_pkg;
    localparam int KEY_W    = 12;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ENTRY = 2'd1;
    localparam logic [1:0] S_CONV  = 2'd2;
    function automatic logic [3:0] key_digit(input logic [KEY_W-1:0] k);
        key_digit = '0;
        for (int i = 0; i < 10; i++)
            if (k[i]) key_digit = 4'(i);
    endfunction
endpackage

// File: rtl/keypad_entry_if.sv
// keypad_entry_if: scanner strobe in, buffer/result/status out of the digit-entry stage.
interface keypad_entry_if #(parameter int DIGITS = 4, parameter int W = 14);
    logic [keypad_pkg::KEY_W-1:0] scan_in;
    logic                         scan_valid;
    logic [4*DIGITS-1:0]          entry_bcd;
    logic [3:0]                   digit_count;
    logic                         busy;
    logic [W-1:0]                 result;
    logic                         result_valid;
    logic                         err;
    modport master (output scan_in, scan_valid, input entry_bcd, digit_count, busy, result, result_valid, err);
    modport slave (input scan_in, scan_valid, output entry_bcd, digit_count, busy, result, result_valid, err);
endinterface

// File: rtl/keypad_bcd2bin.sv
// keypad_bcd2bin: sequential BCD-to-binary, one slot per cycle from the most significant.
module keypad_bcd2bin #(parameter int DIGITS = 4, parameter int W = 14) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd,
    output logic                done,
    output logic [W-1:0]        value
);
    logic         run;
    logic [2:0]   idx;
    logic [W-1:0] acc;
    logic [3:0]   slot;
    // value is the next accumulator; on the last slot it is the final result
    always_comb begin
        slot  = bcd[{idx, 2'b00} +: 4];
        value = (acc << 3) + (acc << 1) + W'(slot);
        done  = run && idx == 3'd0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            idx <= '0;
            acc <= '0;
        end else if (start) begin
            run <= 1'b1;
            idx <= 3'(DIGITS - 1);
            acc <= '0;
        end else if (run) begin
            acc <= value;
            idx <= idx - 1'b1;
            run <= idx != 3'd0;
        end
    end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: keypad digit entry and '#' conversion; KEYPAD_ENTRY_BACKSPACE_EN makes '*' a backspace.
module keypad_entry import keypad_pkg::*; #(parameter int DIGITS = 4, parameter int W = 14) (
    input logic           clk,
    input logic           rst,
    keypad_entry_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    logic [1:0]    state;
    logic [BW-1:0] bcd;
    logic [3:0]    count;
    logic [W-1:0]  result, conv_val;
    logic          result_valid, err, conv_done;
    logic          one_hot, key_ok, is_digit, is_star, is_hash, full, start, err_nxt;
    always_comb begin
        one_hot  = bus.scan_in != '0 && (bus.scan_in & (bus.scan_in - 1'b1)) == '0;
        key_ok   = bus.scan_valid && one_hot;
        is_digit = key_ok && |bus.scan_in[9:0];
        is_star  = key_ok && bus.scan_in[KEY_STAR];
        is_hash  = key_ok && bus.scan_in[KEY_HASH];
        full     = count == 4'(DIGITS);
        start    = is_hash && state == S_ENTRY;
        err_nxt  = (bus.scan_valid && bus.scan_in != '0 && !one_hot) || (key_ok && state == S_CONV)
                 || (is_hash && state == S_EMPTY) || (is_digit && full);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_EMPTY;
            bcd          <= '0;
            count        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            err          <= err_nxt;
            result_valid <= 1'b0;
            if (state == S_CONV) begin
                if (conv_done) begin
                    result       <= conv_val;
                    result_valid <= 1'b1;
                    bcd          <= '0;
                    count        <= '0;
                    state        <= S_EMPTY;
                end
            end else if (is_digit && !full) begin
                bcd   <= (bcd << 4) | BW'(key_digit(bus.scan_in));
                count <= count + 1'b1;
                state <= S_ENTRY;
            end else if (is_star && state == S_ENTRY) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                bcd   <= bcd >> 4;
                count <= count - 1'b1;
                state <= count == 4'd1 ? S_EMPTY : S_ENTRY;
`else
                bcd   <= '0;
                count <= '0;
                state <= S_EMPTY;
`endif
            end else if (start) begin
                state <= S_CONV;
            end
        end
    end
    keypad_bcd2bin #(.DIGITS(DIGITS), .W(W)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .done  (conv_done),
        .value (conv_val)
    );
    assign bus.entry_bcd    = bcd;
    assign bus.digit_count  = count;
    assign bus.busy         = state == S_CONV;
    assign bus.result       = result;
    assign bus.result_valid = result_valid;
    assign bus.err          = err;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed checks of entry, conversion timing, rejects and reset abort.
module tb_keypad_entry;
    localparam logic [11:0] STAR = 12'h400;
    localparam logic [11:0] HASH = 12'h800;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    keypad_entry_if #(.DIGITS(4), .W(14)) bus ();
    keypad_entry #(.DIGITS(4), .W(14)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic key(input logic [11:0] k);
        @(negedge clk);
        bus.scan_in = k;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.scan_in = '0;
    endtask

    // counts negedges from the '#' sampling edge until result_valid, bounded
    task automatic wait_result(input int start, input logic [13:0] exp, input string name);
        int c = start;
        bit seen = 0;
        repeat (12) begin
            if (!seen) begin
                @(negedge clk);
                c++;
                if (bus.result_valid) seen = 1;
            end
        end
        n_checks++;
        if (!seen || c != 4) begin n_fail++; $display("FAIL %s_latency: got seen=%0d cycles=%0d expected seen=1 cycles=4", name, seen, c); end
        n_checks++;
        if (bus.result !== exp) begin n_fail++; $display("FAIL %s_result: got %0d expected %0d", name, bus.result, exp); end
        n_checks++;
        if (bus.entry_bcd !== 16'h0 || bus.digit_count !== 4'd0) begin n_fail++; $display("FAIL %s_cleared: got bcd=%h cnt=%0d expected 0 0", name, bus.entry_bcd, bus.digit_count); end
    endtask

    task automatic no_pulse(input string name);
        bit seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.result_valid) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL %s_no_result_valid: got pulse expected none", name); end
    endtask

    task automatic test_reset;
        bus.scan_in = '0;
        bus.scan_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.entry_bcd !== 16'h0 || bus.digit_count !== 4'd0) begin n_fail++; $display("FAIL reset_buffer: got %h/%0d expected 0/0", bus.entry_bcd, bus.digit_count); end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b rv=%b err=%b expected 0 0 0", bus.busy, bus.result_valid, bus.err); end
        n_checks++;
        if (bus.result !== 14'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", bus.result); end
    endtask

    task automatic test_basic;
        key(12'h002); key(12'h004); key(12'h008);
        n_checks++;
        if (bus.entry_bcd !== 16'h0123 || bus.digit_count !== 4'd3) begin n_fail++; $display("FAIL basic_buffer: got %h/%0d expected 0123/3", bus.entry_bcd, bus.digit_count); end
        key(HASH);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
        wait_result(0, 14'd123, "basic");
        @(negedge clk);
        n_checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_after: got rv=%b busy=%b expected 0 0", bus.result_valid, bus.busy); end
    endtask

    task automatic test_full;
        repeat (4) key(12'h200);
        n_checks++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL full_fourth_err: got %b expected 0", bus.err); end
        key(12'h020);
        n_checks++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL full_fifth_err: got %b expected 1", bus.err); end
        n_checks++;
        if (bus.entry_bcd !== 16'h9999 || bus.digit_count !== 4'd4) begin n_fail++; $display("FAIL full_buffer: got %h/%0d expected 9999/4", bus.entry_bcd, bus.digit_count); end
        key(HASH);
        wait_result(0, 14'd9999, "full");
    endtask

    task automatic test_errors;
        key(HASH);
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL empty_hash: got err=%b busy=%b expected 1 0", bus.err, bus.busy); end
        no_pulse("empty_hash");
        key(STAR);
        n_checks++;
        if (bus.err !== 1'b0 || bus.digit_count !== 4'd0) begin n_fail++; $display("FAIL empty_star: got err=%b cnt=%0d expected 0 0", bus.err, bus.digit_count); end
        key(12'h100);
        key(12'h003);
        n_checks++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL multihot_err: got %b expected 1", bus.err); end
        n_checks++;
        if (bus.entry_bcd !== 16'h0008 || bus.digit_count !== 4'd1) begin n_fail++; $display("FAIL multihot_buffer: got %h/%0d expected 0008/1", bus.entry_bcd, bus.digit_count); end
        key(12'h000);
        n_checks++;
        if (bus.err !== 1'b0 || bus.entry_bcd !== 16'h0008) begin n_fail++; $display("FAIL zero_code: got err=%b bcd=%h expected 0 0008", bus.err, bus.entry_bcd); end
        key(STAR);
        n_checks++;
        if (bus.digit_count !== 4'd0 || bus.entry_bcd !== 16'h0) begin n_fail++; $display("FAIL star_single: got %h/%0d expected 0/0", bus.entry_bcd, bus.digit_count); end
    endtask

    task automatic test_star;
        key(12'h010); key(12'h020); key(STAR);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
        n_checks++;
        if (bus.entry_bcd !== 16'h0004 || bus.digit_count !== 4'd1) begin n_fail++; $display("FAIL star_backspace: got %h/%0d expected 0004/1", bus.entry_bcd, bus.digit_count); end
        key(HASH);
        wait_result(0, 14'd4, "star");
`else
        n_checks++;
        if (bus.entry_bcd !== 16'h0 || bus.digit_count !== 4'd0) begin n_fail++; $display("FAIL star_clear: got %h/%0d expected 0/0", bus.entry_bcd, bus.digit_count); end
        key(HASH);
        n_checks++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL star_hash_err: got %b expected 1", bus.err); end
        no_pulse("star");
        n_checks++;
        if (bus.result !== 14'd9999) begin n_fail++; $display("FAIL star_result_held: got %0d expected 9999", bus.result); end
`endif
    endtask

    task automatic test_conv_keys;
        key(12'h002); key(12'h004); key(HASH);
        bus.scan_in = 12'h080;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.scan_in = '0;
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL conv_key_err: got err=%b busy=%b expected 1 1", bus.err, bus.busy); end
        wait_result(1, 14'd12, "conv_key");
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        bus.scan_in = 12'h008;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_in = 12'h040;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.scan_in = '0;
        n_checks++;
        if (bus.entry_bcd !== 16'h0036 || bus.digit_count !== 4'd2) begin n_fail++; $display("FAIL b2b_buffer: got %h/%0d expected 0036/2", bus.entry_bcd, bus.digit_count); end
        key(HASH);
        wait_result(0, 14'd36, "b2b");
        bus.scan_in = 12'h004;
        bus.scan_valid = 1'b1;
        @(negedge clk);
        bus.scan_valid = 1'b0;
        bus.scan_in = '0;
        n_checks++;
        if (bus.entry_bcd !== 16'h0002 || bus.digit_count !== 4'd1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL b2b_after_done: got %h/%0d err=%b expected 0002/1 0", bus.entry_bcd, bus.digit_count, bus.err); end
    endtask

    task automatic test_reset_abort;
        key(12'h020);
        n_checks++;
        if (bus.entry_bcd !== 16'h0025) begin n_fail++; $display("FAIL abort_buffer: got %h expected 0025", bus.entry_bcd); end
        key(HASH);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.entry_bcd !== 16'h0 || bus.digit_count !== 4'd0 || bus.busy !== 1'b0 || bus.result !== 14'd0 || bus.result_valid !== 1'b0 || bus.err !== 1'b0)
            begin n_fail++; $display("FAIL abort_outputs: got bcd=%h cnt=%0d busy=%b res=%0d rv=%b err=%b expected all 0", bus.entry_bcd, bus.digit_count, bus.busy, bus.result, bus.result_valid, bus.err); end
        @(negedge clk);
        rst = 1'b0;
        no_pulse("abort");
        n_checks++;
        if (bus.result !== 14'd0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_after: got res=%0d busy=%b expected 0 0", bus.result, bus.busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_full;
        test_errors;
        test_star;
        test_conv_keys;
        test_back_to_back;
        test_reset_abort;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
